// File: rtl/pid_sequencer_pkg.sv
// Shared definitions for the PID sample sequencer and its coefficient bank:
// FSM state encoding, coefficient select codes, default timing and the
// saturation limits of the 12-bit control datapath.
package pid_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT    = 3'd2,
    LATCH   = 3'd3,
    RECOVER = 3'd4
  } state_e;

  localparam logic [1:0] COEF_D = 2'd0;
  localparam logic [1:0] COEF_P = 2'd1;
  localparam logic [1:0] COEF_I = 2'd2;

  localparam int DEF_PERIOD  = 50000;
  localparam int DEF_TIMEOUT = 32;

  localparam logic signed [11:0] SAT_MAX = 12'sh7FF;
  localparam logic signed [11:0] SAT_MIN = 12'sh800;

endpackage

// File: rtl/pid_coeff_bank.sv
// Double-buffered PID coefficients: host writes land in shadow registers and
// a commit request is held pending until the sequencer accepts a sample tick,
// at which point the whole set is copied to the active registers at once.
module pid_coeff_bank
  import pid_sequencer_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    i_we,
  input  logic [1:0]              i_sel,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_commit,
  input  logic                    i_load,
  output logic signed [WIDTH-1:0] o_coeff_1,
  output logic signed [WIDTH-1:0] o_coeff_2,
  output logic signed [WIDTH-1:0] o_coeff_3
);

  logic signed [WIDTH-1:0] r_sh_d, r_sh_p, r_sh_i;
  logic signed [WIDTH-1:0] r_act_d, r_act_p, r_act_i;
  logic                    r_pending;
  logic                    w_copy;

  // A commit arriving in the tick cycle itself is honoured on that tick.
  assign w_copy = i_load && (r_pending || i_commit);

  // Shadow write decode; select code 3 has no register behind it.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_sh_d <= '0;
      r_sh_p <= '0;
      r_sh_i <= '0;
    end else if (i_we) begin
      case (i_sel)
        COEF_D:  r_sh_d <= i_data;
        COEF_P:  r_sh_p <= i_data;
        COEF_I:  r_sh_i <= i_data;
        default: ;
      endcase
    end
  end

  // Active set copies the pre-write shadow so a same-cycle write stays in shadow.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_act_d <= '0;
      r_act_p <= '0;
      r_act_i <= '0;
    end else if (w_copy) begin
      r_act_d <= r_sh_d;
      r_act_p <= r_sh_p;
      r_act_i <= r_sh_i;
    end
  end

  // Pending flag remembers a commit until a tick consumes it.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset)         r_pending <= 1'b0;
    else if (w_copy)   r_pending <= 1'b0;
    else if (i_commit) r_pending <= 1'b1;
  end

  assign o_coeff_1 = r_act_d;
  assign o_coeff_2 = r_act_p;
  assign o_coeff_3 = r_act_i;

endmodule

// File: rtl/pid_sequencer.sv
// Sample-rate sequencer for the shared PID datapath: generates the sample
// tick, snapshots measurement and setpoint, fires the datapath start, waits
// for done and latches the servo command.
// Build option PID_TIMEOUT_EN adds the wait timeout and RECOVER sequence
// (pid_rst_o, timeout_o); without it WAIT blocks until done arrives.
module pid_sequencer
  import pid_sequencer_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int PERIOD  = DEF_PERIOD,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] y_k_i,
  input  logic signed [WIDTH-1:0] ref_i,
  input  logic                    cfg_we_i,
  input  logic [1:0]              cfg_sel_i,
  input  logic signed [WIDTH-1:0] cfg_data_i,
  input  logic                    cfg_commit_i,
  output logic                    pid_start_o,
  input  logic                    pid_done_i,
  output logic                    pid_rst_o,
  output logic signed [WIDTH-1:0] pid_y_k_o,
  output logic signed [WIDTH-1:0] pid_ref_o,
  output logic signed [WIDTH-1:0] pid_coeff_1_o,
  output logic signed [WIDTH-1:0] pid_coeff_2_o,
  output logic signed [WIDTH-1:0] pid_coeff_3_o,
  input  logic signed [WIDTH-1:0] pid_servo_i,
  output logic signed [WIDTH-1:0] servo_o,
  output logic                    servo_valid_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    timeout_o
);

  localparam int CNT_W = $clog2(PERIOD);

  state_e                  r_state, w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_tick;
  logic                    w_accept;
  logic signed [WIDTH-1:0] r_y_k, r_ref, r_servo;
  logic                    r_overrun;

  assign w_tick   = en_i && (r_cnt == CNT_W'(PERIOD - 1));
  assign w_accept = (r_state == IDLE) && w_tick;

  // Free-running sample period counter, held at zero while the loop is disabled.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset)                 r_cnt <= '0;
    else if (!en_i || w_tick)  r_cnt <= '0;
    else                       r_cnt <= r_cnt + CNT_W'(1);
  end

`ifdef PID_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT);

  logic [WAIT_W-1:0] r_wait;
  logic              r_rec;
  logic              r_timeout;
  logic              w_expired;

  assign w_expired = (r_wait == WAIT_W'(TIMEOUT - 1));

  // Cycles spent in WAIT; restarts from zero every time WAIT is entered.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset)                 r_wait <= '0;
    else if (r_state == WAIT)  r_wait <= r_wait + WAIT_W'(1);
    else                       r_wait <= '0;
  end

  // Marks the second RECOVER cycle so the datapath reset lasts two cycles.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) r_rec <= 1'b0;
    else       r_rec <= (r_state == RECOVER) && !r_rec;
  end

  // Sticky record that a recovery was started.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset)                                        r_timeout <= 1'b0;
    else if (r_state == WAIT && w_next == RECOVER)    r_timeout <= 1'b1;
  end

  assign pid_rst_o = (r_state == RECOVER);
  assign timeout_o = r_timeout;
`else
  assign pid_rst_o = 1'b0;
  assign timeout_o = 1'b0;

  // TIMEOUT only shapes hardware when recovery is built in.
  if (TIMEOUT > 0) begin : g_no_recovery
  end
`endif

  // State register; asynchronous reset drops every state-decoded output at once.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; done outside WAIT is ignored and done beats the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_next = ARM;
      ARM:     w_next = WAIT;
      WAIT: begin
        if (pid_done_i) w_next = LATCH;
`ifdef PID_TIMEOUT_EN
        else if (w_expired) w_next = RECOVER;
`endif
      end
      LATCH:   w_next = IDLE;
`ifdef PID_TIMEOUT_EN
      RECOVER: if (r_rec) w_next = IDLE;
`else
      RECOVER: w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Snapshot of plant and setpoint, frozen for the whole datapath run.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_y_k <= '0;
      r_ref <= '0;
    end else if (w_accept) begin
      r_y_k <= y_k_i;
      r_ref <= ref_i;
    end
  end

  // Servo result captured on the done cycle so it is presented in LATCH.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset)                              r_servo <= '0;
    else if (r_state == WAIT && pid_done_i) r_servo <= pid_servo_i;
  end

  // Sticky flag for ticks dropped because the previous run had not finished.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset)                           r_overrun <= 1'b0;
    else if (w_tick && r_state != IDLE)  r_overrun <= 1'b1;
  end

  pid_coeff_bank #(
    .WIDTH(WIDTH)
  ) u_coeff_bank (
    .clk_i     (clk_i),
    .reset     (reset),
    .i_we      (cfg_we_i),
    .i_sel     (cfg_sel_i),
    .i_data    (cfg_data_i),
    .i_commit  (cfg_commit_i),
    .i_load    (w_accept),
    .o_coeff_1 (pid_coeff_1_o),
    .o_coeff_2 (pid_coeff_2_o),
    .o_coeff_3 (pid_coeff_3_o)
  );

  assign pid_start_o   = (r_state == ARM);
  assign servo_valid_o = (r_state == LATCH);
  assign busy_o        = (r_state != IDLE);
  assign pid_y_k_o     = r_y_k;
  assign pid_ref_o     = r_ref;
  assign servo_o       = r_servo;
  assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_pid_sequencer.sv
// Scoreboard bench for pid_sequencer with PERIOD=40, TIMEOUT=32. A datapath
// model answers each start after a programmable latency with
// servo = ref - y + P, computed from the presented snapshot and coefficient.
module tb_pid_sequencer;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        en_i;
  logic [11:0] y_k_i, ref_i, cfg_data_i;
  logic        cfg_we_i, cfg_commit_i;
  logic [1:0]  cfg_sel_i;
  logic        pid_start_o, pid_done_i, pid_rst_o;
  logic [11:0] pid_y_k_o, pid_ref_o, pid_coeff_1_o, pid_coeff_2_o, pid_coeff_3_o;
  logic [11:0] pid_servo_i, servo_o;
  logic        servo_valid_o, busy_o, overrun_o, timeout_o;

  pid_sequencer #(.WIDTH(12), .PERIOD(40), .TIMEOUT(32)) dut (
    .clk_i(clk_i), .reset(reset), .en_i(en_i), .y_k_i(y_k_i), .ref_i(ref_i),
    .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i),
    .cfg_commit_i(cfg_commit_i), .pid_start_o(pid_start_o), .pid_done_i(pid_done_i),
    .pid_rst_o(pid_rst_o), .pid_y_k_o(pid_y_k_o), .pid_ref_o(pid_ref_o),
    .pid_coeff_1_o(pid_coeff_1_o), .pid_coeff_2_o(pid_coeff_2_o),
    .pid_coeff_3_o(pid_coeff_3_o), .pid_servo_i(pid_servo_i), .servo_o(servo_o),
    .servo_valid_o(servo_valid_o), .busy_o(busy_o), .overrun_o(overrun_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] val;
    int          at;
  } exp_t;

  exp_t sq[$];
  int   stq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat     = 10;
  int   dcnt    = 0;
  int   e, f, g, h;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic push_servo(input logic [11:0] v, input int at);
    exp_t x;
    x.val = v;
    x.at  = at;
    sq.push_back(x);
  endtask

  // Datapath model: done pulse lat cycles after start (lat <= 0: never).
  initial begin
    pid_done_i  = 1'b0;
    pid_servo_i = 12'h5A5;
    forever begin
      @(posedge clk_i);
      #1;
      pid_done_i  = 1'b0;
      pid_servo_i = 12'h5A5;
      if (pid_start_o) begin
        if (lat > 0) dcnt = lat;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          pid_done_i  = 1'b1;
          pid_servo_i = pid_ref_o - pid_y_k_o + pid_coeff_2_o;
        end
      end
    end
  end

  // Monitor: every start and every servo update must match the scoreboard.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk_i);
      if (pid_start_o) begin
        if (stq.size() == 0) chk_int("unexpected_start_cycle", cyc, -1);
        else chk_int("start_cycle", cyc, stq.pop_front());
      end
      if (servo_valid_o) begin
        if (sq.size() == 0) chk_int("unexpected_servo_cycle", cyc, -1);
        else begin
          x = sq.pop_front();
          chk("servo_value", servo_o, x.val);
          chk_int("servo_cycle", cyc, x.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en_i = 1'b0; y_k_i = '0; ref_i = '0;
    cfg_we_i = 1'b0; cfg_sel_i = '0; cfg_data_i = '0; cfg_commit_i = 1'b0;
    wait_to(3);
    chk("rst_busy", {11'd0, busy_o}, 12'd0);
    chk("rst_start", {11'd0, pid_start_o}, 12'd0);
    chk("rst_pid_rst", {11'd0, pid_rst_o}, 12'd0);
    chk("rst_valid", {11'd0, servo_valid_o}, 12'd0);
    chk("rst_servo", servo_o, 12'd0);
    chk("rst_overrun", {11'd0, overrun_o}, 12'd0);
    chk("rst_timeout", {11'd0, timeout_o}, 12'd0);
    chk("rst_coeff_p", pid_coeff_2_o, 12'd0);
    reset = 1'b0;

    // Nominal loop, coefficient double-buffering and snapshot stability.
    wait_to(5);
    e = cyc; y_k_i = 12'd100; ref_i = 12'd80; en_i = 1'b1;
    for (int k = 1; k <= 8; k++) stq.push_back(e + 40 * k);
    push_servo(12'hFEC, e + 51);  push_servo(12'hFEC, e + 91);
    push_servo(12'hFFC, e + 131); push_servo(12'hFFC, e + 171);
    push_servo(12'hFFC, e + 211); push_servo(12'h00C, e + 251);
    push_servo(12'h340, e + 291); push_servo(12'h214, e + 331);
    wait_to(e + 41);
    chk("snap_y", pid_y_k_o, 12'd100);
    chk("snap_ref", pid_ref_o, 12'd80);
    wait_to(e + 100); cfg_we_i = 1'b1; cfg_sel_i = 2'd1; cfg_data_i = 12'h010;
    wait_to(e + 101); cfg_sel_i = 2'd3; cfg_data_i = 12'h7AA;
    wait_to(e + 102); cfg_we_i = 1'b0; cfg_commit_i = 1'b1;
    wait_to(e + 103); cfg_commit_i = 1'b0;
    chk("coef_p_before_tick", pid_coeff_2_o, 12'h000);
    wait_to(e + 119);
    chk("coef_p_at_tick", pid_coeff_2_o, 12'h000);
    wait_to(e + 120);
    chk("coef_p_after_tick", pid_coeff_2_o, 12'h010);
    chk("coef_d_sel3", pid_coeff_1_o, 12'h000);
    chk("coef_i_sel3", pid_coeff_3_o, 12'h000);
    wait_to(e + 159); cfg_we_i = 1'b1; cfg_sel_i = 2'd1; cfg_data_i = 12'h020; cfg_commit_i = 1'b1;
    wait_to(e + 160); cfg_we_i = 1'b0; cfg_commit_i = 1'b0;
    chk("coef_p_same_tick_write", pid_coeff_2_o, 12'h010);
    wait_to(e + 200);
    chk("coef_p_no_pending", pid_coeff_2_o, 12'h010);
    wait_to(e + 210); cfg_commit_i = 1'b1;
    wait_to(e + 211); cfg_commit_i = 1'b0;
    wait_to(e + 240);
    chk("coef_p_shadow_kept", pid_coeff_2_o, 12'h020);
    wait_to(e + 250); y_k_i = 12'hED4; ref_i = 12'd500;
    wait_to(e + 281);
    chk("snap_y_negative", pid_y_k_o, 12'hED4);
    wait_to(e + 285); y_k_i = 12'd0;
    wait_to(e + 288);
    chk("snap_y_held_busy", pid_y_k_o, 12'hED4);
    wait_to(e + 335); en_i = 1'b0;

    // Done arriving in the same cycle the wait limit is reached.
    wait_to(e + 340);
    f = cyc; lat = 32; en_i = 1'b1;
    stq.push_back(f + 40);
    push_servo(12'h214, f + 73);
    wait_to(f + 73);
    chk("busy_in_latch", {11'd0, busy_o}, 12'd1);
    wait_to(f + 74); en_i = 1'b0;
    chk("busy_fall", {11'd0, busy_o}, 12'd0);
    chk("timeout_done_wins", {11'd0, timeout_o}, 12'd0);

    // Stalled / slow datapath.
    wait_to(f + 80);
    g = cyc; ref_i = 12'd200;
`ifdef PID_TIMEOUT_EN
    lat = -1;
    stq.push_back(g + 40); stq.push_back(g + 80); stq.push_back(g + 120);
`else
    lat = 50;
    stq.push_back(g + 40); stq.push_back(g + 120);
`endif
    push_servo(12'h0E8, g + 91); push_servo(12'h0E8, g + 131);
    en_i = 1'b1;
`ifdef PID_TIMEOUT_EN
    wait_to(g + 72);
    chk("rec_rst_before", {11'd0, pid_rst_o}, 12'd0);
    wait_to(g + 73);
    chk("rec_rst_cycle1", {11'd0, pid_rst_o}, 12'd1);
    chk("rec_timeout_flag", {11'd0, timeout_o}, 12'd1);
    wait_to(g + 74);
    chk("rec_rst_cycle2", {11'd0, pid_rst_o}, 12'd1);
    wait_to(g + 75);
    chk("rec_rst_after", {11'd0, pid_rst_o}, 12'd0);
    chk("rec_idle", {11'd0, busy_o}, 12'd0);
    wait_to(g + 76); lat = 10;
    chk("rec_servo_held", servo_o, 12'h214);
    wait_to(g + 95);
    chk("rec_no_overrun", {11'd0, overrun_o}, 12'd0);
`else
    wait_to(g + 79);
    chk("overrun_before", {11'd0, overrun_o}, 12'd0);
    wait_to(g + 80);
    chk("overrun_set", {11'd0, overrun_o}, 12'd1);
    chk("overrun_busy", {11'd0, busy_o}, 12'd1);
    chk("no_pid_rst", {11'd0, pid_rst_o}, 12'd0);
    wait_to(g + 95); lat = 10;
    chk("no_timeout", {11'd0, timeout_o}, 12'd0);
`endif
    wait_to(g + 135); en_i = 1'b0;

    // Asynchronous reset while waiting for done; the late done must be ignored.
    wait_to(g + 140);
    h = cyc; en_i = 1'b1;
    stq.push_back(h + 40);
    wait_to(h + 45);
    #2 reset = 1'b1; en_i = 1'b0;
    #1;
    chk("mid_rst_busy", {11'd0, busy_o}, 12'd0);
    chk("mid_rst_start", {11'd0, pid_start_o}, 12'd0);
    chk("mid_rst_servo", servo_o, 12'd0);
    chk("mid_rst_ref", pid_ref_o, 12'd0);
    chk("mid_rst_coeff_p", pid_coeff_2_o, 12'd0);
    chk("mid_rst_overrun", {11'd0, overrun_o}, 12'd0);
    chk("mid_rst_timeout", {11'd0, timeout_o}, 12'd0);
    wait_to(h + 47); reset = 1'b0;
    wait_to(h + 53);
    chk("stray_done_busy", {11'd0, busy_o}, 12'd0);
    chk("stray_done_servo", servo_o, 12'd0);

    chk_int("pending_starts", stq.size(), 0);
    chk_int("pending_servos", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
